xbar_host_arb: RTL and testbench



---
 rtl/tlul_pkg.sv | 41 ++++
 rtl/xbar_pkg.sv | 24 ++
 rtl/xbar_arb_idx_fifo.sv | 60 ++++++
 rtl/xbar_host_arb.sv | 175 +++++++++++++++++
 tb/tb_xbar_host_arb.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlul_pkg.sv
// TL-UL channel types shared by hosts, arbiter and crossbar.
// Latency: n/a (types only).
// Backpressure: n/a (a_ready/d_ready are carried in the structs).
//
// Contents: A-channel request (host to device) and D-channel response
// (device to host) structs, plus the opcodes used on this bus.
package tlul_pkg;

  localparam logic [2:0] TlPutFullData    = 3'h0;
  localparam logic [2:0] TlPutPartialData = 3'h1;
  localparam logic [2:0] TlGet            = 3'h4;
  localparam logic [2:0] TlAccessAck      = 3'h0;
  localparam logic [2:0] TlAccessAckData  = 3'h1;

  // Host-to-device: A channel request plus the host's D-channel ready.
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  // Device-to-host: D channel response plus the device's A-channel ready.
  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/xbar_pkg.sv
// Shared constants and helpers for the crossbar host arbiter.
// Latency: n/a (types and a pure function).
// Backpressure: n/a.
//
// Contents: host-count ceiling, host index type, default outstanding depth,
// and a modulo-N host index increment.
package xbar_pkg;

  localparam int XbarMaxHosts        = 4;
  localparam int XbarArbOutstDefault = 2;

  typedef logic [1:0] xbar_host_idx_t;

  // (base + off) mod n, for off < n and base < n.
  function automatic xbar_host_idx_t xbar_host_add(input xbar_host_idx_t base,
                                                   input int unsigned    off,
                                                   input int unsigned    n);
    int unsigned sum;
    sum = int'(base) + off;
    if (sum >= n) sum = sum - n;
    return xbar_host_idx_t'(sum);
  endfunction

endpackage

// File: rtl/xbar_arb_idx_fifo.sv
// In-order tracking FIFO of granted host indices.
// Latency: push visible at head one cycle later; head/full/empty are registered state.
// Backpressure: push ignored when full, pop ignored when empty; the owner gates both.
//
// Ports: clk_i, rst_ni (async active-low), push_i/push_dat_i, pop_i,
//        head_o (oldest entry), full_o, empty_o.
module xbar_arb_idx_fifo
  import xbar_pkg::*;
#(
  parameter int Depth = XbarArbOutstDefault
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           push_i,
  input  xbar_host_idx_t push_dat_i,
  input  logic           pop_i,
  output xbar_host_idx_t head_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth) + 1;

  xbar_host_idx_t  mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push;
  logic            do_pop;

  // Depth need not fill the pointer range, so wrap explicitly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CntW'(1);
      else if (!do_push && do_pop) cnt_q <= cnt_q - CntW'(1);
    end
  end

endmodule

// File: rtl/xbar_host_arb.sv
// Shares one TL-UL upstream crossbar port among NumHosts hosts; D beats return in request order.
// Latency: zero-cycle combinational A grant and D routing; pointer/lock/FIFO update on clk_i.
// Backpressure: only the granted host sees device a_ready; full tracking FIFO stalls all
//               hosts; the head host's d_ready throttles the device D channel.
//
// Ports: clk_i, rst_ni (async active-low); tl_h_i/tl_h_o host side [NumHosts];
//        tl_d_o/tl_d_i crossbar side; busy_o (requests outstanding);
//        spurious_o (one-cycle pulse after a D beat arrives with nothing outstanding).
// Build option: define XBAR_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins)
//               instead of round-robin.
module xbar_host_arb
  import tlul_pkg::*;
  import xbar_pkg::*;
#(
  parameter int NumHosts = 2,
  parameter int MaxOutst = XbarArbOutstDefault
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_h_i [NumHosts],
  output tl_d2h_t tl_h_o [NumHosts],
  output tl_h2d_t tl_d_o,
  input  tl_d2h_t tl_d_i,
  output logic    busy_o,
  output logic    spurious_o
);

  // Padded to the maximum host count so a 2-bit host index always selects in range.
  logic [XbarMaxHosts-1:0] req;
  logic [XbarMaxHosts-1:0] host_d_rdy;

  xbar_host_idx_t gnt;
  xbar_host_idx_t head;
  tl_h2d_t        gnt_req;
  logic           head_d_rdy;

  logic           lock_q;
  logic           lock_d;
  xbar_host_idx_t lock_idx_q;
  xbar_host_idx_t lock_idx_d;

  logic           fifo_full;
  logic           fifo_empty;
  logic           a_hs;
  logic           d_hs;
  logic           spurious_q;

  always_comb begin
    req        = '0;
    host_d_rdy = '0;
    for (int i = 0; i < NumHosts; i++) begin
      req[i]        = tl_h_i[i].a_valid;
      host_d_rdy[i] = tl_h_i[i].d_ready;
    end
  end

`ifdef XBAR_ARB_FIXED_PRIO_EN
  // Fixed priority: scan downward so the lowest requesting index is the last write.
  always_comb begin
    gnt = '0;
    if (!rst_ni) begin
      gnt = '0;
    end else if (lock_q) begin
      gnt = lock_idx_q;
    end else begin
      for (int i = NumHosts - 1; i >= 0; i--) begin
        if (req[i]) gnt = xbar_host_idx_t'(i);
      end
    end
  end
`else
  xbar_host_idx_t rr_ptr_q;
  xbar_host_idx_t rr_cand;
  logic           rr_found;

  // Round-robin: first requester at or after rr_ptr_q, wrapping at NumHosts.
  always_comb begin
    gnt      = '0;
    rr_cand  = '0;
    rr_found = 1'b0;
    if (!rst_ni) begin
      gnt = '0;
    end else if (lock_q) begin
      gnt = lock_idx_q;
    end else begin
      for (int off = 0; off < NumHosts; off++) begin
        rr_cand = xbar_host_add(rr_ptr_q, off, NumHosts);
        if (!rr_found && req[rr_cand]) begin
          gnt      = rr_cand;
          rr_found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (a_hs) begin
      rr_ptr_q <= xbar_host_add(gnt, 1, NumHosts);
    end
  end
`endif

  // With no requester gnt is 0, so idle A fields come from host 0 and a_valid is low.
  // Reset also parks gnt on host 0 so a_valid tracks host 0 while rst_ni is low.
  always_comb begin
    gnt_req    = tl_h_i[0];
    head_d_rdy = host_d_rdy[head];
    for (int i = 0; i < NumHosts; i++) begin
      if (gnt == xbar_host_idx_t'(i)) gnt_req = tl_h_i[i];
    end
  end

  // Full is registered state, so a same-cycle pop never opens the A path (no D-to-A comb path).
  // An empty FIFO accepts and drops any D beat rather than stalling the crossbar.
  always_comb begin
    tl_d_o         = gnt_req;
    tl_d_o.a_valid = gnt_req.a_valid & ~fifo_full;
    tl_d_o.d_ready = fifo_empty ? 1'b1 : head_d_rdy;
  end

  assign a_hs = tl_d_o.a_valid & tl_d_i.a_ready;
  assign d_hs = tl_d_i.d_valid & tl_d_o.d_ready;

  always_comb begin
    for (int i = 0; i < NumHosts; i++) begin
      tl_h_o[i]         = tl_d_i;
      tl_h_o[i].a_ready = (gnt == xbar_host_idx_t'(i)) & tl_d_i.a_ready & ~fifo_full;
      tl_h_o[i].d_valid = (head == xbar_host_idx_t'(i)) & tl_d_i.d_valid & ~fifo_empty;
    end
  end

  // Once a request has been presented and stalled, hold the grant on that host until
  // it handshakes so the A channel stays stable.
  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (lock_q) begin
      if (a_hs) lock_d = 1'b0;
    end else if (gnt_req.a_valid && !tl_d_i.a_ready) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      spurious_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      spurious_q <= tl_d_i.d_valid & fifo_empty;
    end
  end

  xbar_arb_idx_fifo #(
    .Depth(MaxOutst)
  ) u_idx_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (a_hs),
    .push_dat_i(gnt),
    .pop_i     (d_hs & ~fifo_empty),
    .head_o    (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign busy_o     = ~fifo_empty;
  assign spurious_o = spurious_q;

endmodule

// File: tb/tb_xbar_host_arb.sv
// Directed bench for xbar_host_arb with two hosts and two outstanding requests.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_xbar_host_arb;
  import tlul_pkg::*;

  logic    clk;
  logic    rst_n;
  tl_h2d_t h_req [2];
  tl_d2h_t h_rsp [2];
  tl_h2d_t d_req;
  tl_d2h_t d_rsp;
  logic    busy;
  logic    spurious;

  int errors = 0;
  int checks = 0;

  xbar_host_arb #(
    .NumHosts(2),
    .MaxOutst(2)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .tl_h_i    (h_req),
    .tl_h_o    (h_rsp),
    .tl_d_o    (d_req),
    .tl_d_i    (d_rsp),
    .busy_o    (busy),
    .spurious_o(spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    for (int h = 0; h < 2; h++) begin
      h_req[h]           = '0;
      h_req[h].a_opcode  = TlGet;
      h_req[h].a_size    = 2'd2;
      h_req[h].a_mask    = 4'hf;
      h_req[h].a_source  = 8'(h);
      h_req[h].a_address = 32'h4000_0000 + 32'(h) * 32'h100;
      h_req[h].d_ready   = 1'b1;
    end
    d_rsp          = '0;
    d_rsp.d_opcode = TlAccessAckData;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clr_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  int busy_n;
  int beats;
  int h1_seen;
  int exp_gnt [4];

  initial begin
    rst_n = 1'b0;
    clr_inputs();
    // Reset behaviour: a_valid follows host 0 only, no D routing, idle status.
    h_req[1].a_valid = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_spurious", 32'(spurious), 0);
    chk("rst_avld_h1_only", 32'(d_req.a_valid), 0);
    h_req[0].a_valid = 1'b1;
    #1;
    chk("rst_avld_h0", 32'(d_req.a_valid), 1);
    d_rsp.d_valid = 1'b1;
    #1;
    chk("rst_h0_dvld", 32'(h_rsp[0].d_valid), 0);
    chk("rst_h1_dvld", 32'(h_rsp[1].d_valid), 0);
    do_reset();

    // Single host Get, device answers 3 cycles after the handshake.
    tick();
    h_req[0].a_valid = 1'b1;
    d_rsp.a_ready    = 1'b1;
    #1;
    chk("t1_avld", 32'(d_req.a_valid), 1);
    chk("t1_addr", d_req.a_address, 32'h4000_0000);
    chk("t1_opcode", 32'(d_req.a_opcode), 32'(TlGet));
    chk("t1_h0_ardy", 32'(h_rsp[0].a_ready), 1);
    chk("t1_h1_ardy", 32'(h_rsp[1].a_ready), 0);
    busy_n  = 0;
    beats   = 0;
    h1_seen = 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      h_req[0].a_valid = 1'b0;
      d_rsp.d_valid    = (k == 3);
      d_rsp.d_data     = 32'hcafe_0001;
      #1;
      if (busy) busy_n++;
      if (h_rsp[0].d_valid && d_req.d_ready) beats++;
      if (h_rsp[1].d_valid) h1_seen++;
    end
    chk("t1_busy_cycles", 32'(busy_n), 4);
    chk("t1_h0_beats", 32'(beats), 1);
    chk("t1_h1_dvld_seen", 32'(h1_seen), 0);
    do_reset();

    // Contention: both hosts request every cycle; device always ready.
`ifdef XBAR_ARB_FIXED_PRIO_EN
    exp_gnt = '{0, 0, 0, 0};
`else
    exp_gnt = '{0, 1, 0, 1};
`endif
    for (int k = 0; k < 4; k++) begin
      tick();
      h_req[0].a_valid = 1'b1;
      h_req[1].a_valid = 1'b1;
      d_rsp.a_ready    = 1'b1;
      d_rsp.d_valid    = (k > 0);
      #1;
      chk($sformatf("t2_gnt%0d", k), 32'(d_req.a_source), 32'(exp_gnt[k]));
      chk($sformatf("t2_avld%0d", k), 32'(d_req.a_valid), 1);
    end
    do_reset();

    // Lock: host 1 stalls 5 cycles; host 0 joins in cycle 2 and must wait.
    for (int k = 0; k < 7; k++) begin
      tick();
      h_req[1].a_valid = (k <= 5);
      h_req[0].a_valid = (k >= 2);
      d_rsp.a_ready    = (k >= 5);
      #1;
      chk($sformatf("t3_src%0d", k), 32'(d_req.a_source), (k <= 5) ? 1 : 0);
      chk($sformatf("t3_h0_ardy%0d", k), 32'(h_rsp[0].a_ready), (k == 6) ? 1 : 0);
    end
    do_reset();

    // Full: two accepted, third blocked until one pop has completed.
    tick();
    h_req[0].a_valid = 1'b1;
    d_rsp.a_ready    = 1'b1;
    tick();
    #1;
    chk("t4_second_ardy", 32'(h_rsp[0].a_ready), 1);
    tick();
    h_req[0].a_valid = 1'b0;
    h_req[1].a_valid = 1'b1;
    #1;
    chk("t4_full_h1_ardy", 32'(h_rsp[1].a_ready), 0);
    chk("t4_full_avld", 32'(d_req.a_valid), 0);
    chk("t4_full_busy", 32'(busy), 1);
    tick();
    d_rsp.d_valid = 1'b1;
    #1;
    chk("t4_pop_h0_dvld", 32'(h_rsp[0].d_valid), 1);
    chk("t4_popcyc_h1_ardy", 32'(h_rsp[1].a_ready), 0);
    tick();
    d_rsp.d_valid = 1'b0;
    #1;
    chk("t4_after_h1_ardy", 32'(h_rsp[1].a_ready), 1);
    chk("t4_after_avld", 32'(d_req.a_valid), 1);
    do_reset();

    // Ordering: host0, host1, host0; host 1 back-pressures its beat once.
    tick();
    h_req[0].a_valid = 1'b1;
    d_rsp.a_ready    = 1'b1;
    tick();
    h_req[0].a_valid = 1'b0;
    h_req[1].a_valid = 1'b1;
    tick();
    h_req[1].a_valid = 1'b0;
    h_req[0].a_valid = 1'b1;
    d_rsp.d_valid    = 1'b1;
    d_rsp.d_data     = 32'h0000_00a0;
    #1;
    chk("t5_b0_h0_dvld", 32'(h_rsp[0].d_valid), 1);
    chk("t5_b0_h1_dvld", 32'(h_rsp[1].d_valid), 0);
    chk("t5_b0_h0_data", h_rsp[0].d_data, 32'h0000_00a0);
    chk("t5_b0_h0_ardy_full", 32'(h_rsp[0].a_ready), 0);
    tick();
    d_rsp.d_data     = 32'h0000_00b1;
    h_req[1].d_ready = 1'b0;
    #1;
    chk("t5_b1_h1_dvld", 32'(h_rsp[1].d_valid), 1);
    chk("t5_b1_h0_dvld", 32'(h_rsp[0].d_valid), 0);
    chk("t5_b1_dev_drdy_held", 32'(d_req.d_ready), 0);
    chk("t5_third_h0_ardy", 32'(h_rsp[0].a_ready), 1);
    tick();
    h_req[0].a_valid = 1'b0;
    h_req[1].d_ready = 1'b1;
    #1;
    chk("t5_b1_dev_drdy", 32'(d_req.d_ready), 1);
    chk("t5_b1_h1_data", h_rsp[1].d_data, 32'h0000_00b1);
    tick();
    d_rsp.d_data = 32'h0000_00c2;
    #1;
    chk("t5_b2_h0_dvld", 32'(h_rsp[0].d_valid), 1);
    chk("t5_b2_h1_dvld", 32'(h_rsp[1].d_valid), 0);
    chk("t5_b2_h0_data", h_rsp[0].d_data, 32'h0000_00c2);
    tick();
    d_rsp.d_valid = 1'b0;
    #1;
    chk("t5_drained_busy", 32'(busy), 0);
    do_reset();

    // Spurious D beat with nothing outstanding.
    tick();
    d_rsp.d_valid = 1'b1;
    #1;
    chk("t6_drdy_empty", 32'(d_req.d_ready), 1);
    chk("t6_h0_dvld", 32'(h_rsp[0].d_valid), 0);
    chk("t6_h1_dvld", 32'(h_rsp[1].d_valid), 0);
    chk("t6_spur_before", 32'(spurious), 0);
    tick();
    d_rsp.d_valid = 1'b0;
    #1;
    chk("t6_spur_pulse", 32'(spurious), 1);
    tick();
    #1;
    chk("t6_spur_after", 32'(spurious), 0);

    // Reset asserted with two requests outstanding.
    tick();
    h_req[0].a_valid = 1'b1;
    d_rsp.a_ready    = 1'b1;
    tick();
    tick();
    h_req[0].a_valid = 1'b0;
    #1;
    chk("t7_busy_before_rst", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t7_busy_in_rst", 32'(busy), 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("t7_busy_after_rst", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
